// File: rtl/dm_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache controller.
package dm_cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int DEF_INDEX_BITS = 9;
    localparam int DEF_DATA_W     = 32;
    localparam int TAG_BITS       = 30 - DEF_INDEX_BITS;

    // Tag width left over once the word offset and index are removed from a 32-bit byte address.
    function automatic int tag_bits(input int index_bits);
        return 30 - index_bits;
    endfunction

endpackage

// File: rtl/dm_cache_arrays.sv
// Valid/tag/data storage: asynchronous read, one synchronous write port.
module dm_cache_arrays
    import dm_cache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_W      = tag_bits(DEF_INDEX_BITS),
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  tv_we,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  data_we,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  valid_r;
    logic [TAG_W-1:0]  tag_mem_r  [LINES];
    logic [DATA_W-1:0] data_mem_r [LINES];

    // Valid bits: cleared on reset, set when a line is filled
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else if (tv_we) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag storage, written only on a fill
    always_ff @(posedge clk) begin
        if (tv_we) begin
            tag_mem_r[wr_idx] <= wr_tag;
        end
    end

    // Data storage, written on a fill or a write hit
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_mem_r[rd_idx];
    assign rd_data  = data_mem_r[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through/no-write-allocate cache controller with a
// single outstanding req/ack transaction to backing memory.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TAG_W = tag_bits(INDEX_BITS);

    state_t              state_r, state_next_s;
    logic [29:0]         word_addr_r;
    logic                rw_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                cpu_valid_r, mem_req_r, mem_we_r;
    logic [DATA_W-1:0]   cpu_rdata_r, mem_wdata_r;
    logic [31:0]         mem_addr_r;
    logic [CNT_W-1:0]    hit_cnt_r, miss_cnt_r;

    logic [INDEX_BITS-1:0] idx_s;
    logic [TAG_W-1:0]      tag_s, line_tag_s;
    logic                  line_valid_s, hit_s, fill_s, wr_hit_s;
    logic [DATA_W-1:0]     line_data_s;
    logic                  addr_lo_unused_s;

    assign addr_lo_unused_s = ^cpu_addr[1:0];
    assign idx_s = word_addr_r[INDEX_BITS-1:0];
    assign tag_s = word_addr_r[29:INDEX_BITS];
    assign hit_s = line_valid_s && (line_tag_s == tag_s);

    dm_cache_arrays #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) u_arrays (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx_s),
        .rd_valid (line_valid_s),
        .rd_tag   (line_tag_s),
        .rd_data  (line_data_s),
        .wr_idx   (idx_s),
        .tv_we    (fill_s && !rst),
        .wr_tag   (tag_s),
        .data_we  ((fill_s || wr_hit_s) && !rst),
        .wr_data  (fill_s ? mem_rdata : wdata_r)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode plus array write strobes
    always_comb begin
        state_next_s = state_r;
        fill_s       = 1'b0;
        wr_hit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu_req) state_next_s = LOOKUP;
                else         state_next_s = IDLE;
            end
            LOOKUP: begin
                if (rw_r == RW_WRITE) begin
                    state_next_s = MEM_WR;
                    wr_hit_s     = hit_s;
                end else if (hit_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    state_next_s = IDLE;
                    fill_s       = 1'b1;
                end else begin
                    state_next_s = MEM_RD;
                end
            end
            MEM_WR: begin
                if (mem_ack) state_next_s = IDLE;
                else         state_next_s = MEM_WR;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Request capture in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            word_addr_r <= 30'd0;
            rw_r        <= RW_READ;
            wdata_r     <= '0;
        end else if (state_r == IDLE && cpu_req) begin
            word_addr_r <= cpu_addr[31:2];
            rw_r        <= cpu_rw;
            wdata_r     <= cpu_wdata;
        end
    end

    // Registered CPU/memory outputs and hit/miss counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_valid_r <= 1'b0;
            cpu_rdata_r <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= '0;
            hit_cnt_r   <= '0;
            miss_cnt_r  <= '0;
        end else begin
            cpu_valid_r <= 1'b0;
            case (state_r)
                LOOKUP: begin
                    if (rw_r == RW_WRITE) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= {word_addr_r, 2'b00};
                        mem_wdata_r <= wdata_r;
                    end else if (hit_s) begin
                        cpu_rdata_r <= line_data_s;
                        cpu_valid_r <= 1'b1;
                        hit_cnt_r   <= hit_cnt_r + CNT_W'(1);
                    end else begin
                        miss_cnt_r  <= miss_cnt_r + CNT_W'(1);
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= {word_addr_r, 2'b00};
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        cpu_rdata_r <= mem_rdata;
                        cpu_valid_r <= 1'b1;
                        mem_req_r   <= 1'b0;
                    end
                end
                MEM_WR: begin
                    if (mem_ack) begin
                        cpu_valid_r <= 1'b1;
                        mem_req_r   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu_ready  = (state_r == IDLE);
    assign cpu_valid  = cpu_valid_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign hit_count  = hit_cnt_r;
    assign miss_count = miss_cnt_r;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench: transaction-level cache/memory model predicts every
// cycle's outputs; directed scenarios plus randomized traffic.
module tb_dm_cache_ctrl;

    localparam int IB = 9;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, cpu_req, cpu_rw, mem_ack;
    logic [31:0]   cpu_addr, cpu_wdata, mem_rdata;
    logic          cpu_ready, cpu_valid, mem_req, mem_we;
    logic [31:0]   cpu_rdata, mem_addr, mem_wdata;
    logic [CW-1:0] hit_count, miss_count;

    dm_cache_ctrl #(.INDEX_BITS(IB), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle
    bit            exp_ready, exp_valid, exp_rd, exp_req, exp_we;
    logic [31:0]   exp_rdata, exp_addr, exp_wdata;
    logic [CW-1:0] exp_hit, exp_miss;

    // Cache contents as "which word address lives in each line", plus backing memory image
    bit          line_ok   [512];
    logic [29:0] line_word [512];
    logic [31:0] line_data [512];
    logic [31:0] mem_img   [logic [29:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] w);
        if (mem_img.exists(w)) return mem_img[w];
        return {w[15:0], ~w[15:0]};
    endfunction

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cpu_ready", 32'(cpu_ready), 32'(exp_ready));
            check("cpu_valid", 32'(cpu_valid), 32'(exp_valid));
            check("mem_req", 32'(mem_req), 32'(exp_req));
            check("hit_count", 32'(hit_count), 32'(exp_hit));
            check("miss_count", 32'(miss_count), 32'(exp_miss));
            if (exp_valid && exp_rd) check("cpu_rdata", cpu_rdata, exp_rdata);
            if (exp_req) begin
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_addr", mem_addr, exp_addr);
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        exp_valid = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 512; i++) line_ok[i] = 1'b0;
        exp_ready = 1'b1; exp_valid = 1'b0; exp_rd = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
        exp_rdata = 32'd0; exp_addr = 32'd0; exp_wdata = 32'd0;
        exp_hit = '0; exp_miss = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; cpu_req = 1'b0; mem_ack = 1'b0;
        step();
        model_reset();
        chk_en = 1'b1;
        rst = 1'b0;
    endtask

    // One CPU transaction; returns in the cycle cpu_valid is expected high.
    task automatic do_txn(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                          input int dly, input bit hold);
        logic [29:0] w;
        int idx;
        bit hit;
        w = addr[31:2];
        idx = int'(w[8:0]);
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
        step();
        if (!hold) cpu_req = 1'b0;
        exp_ready = 1'b0;
        hit = line_ok[idx] && (line_word[idx] == w);
        step();
        if (!rw && hit) begin
            exp_valid = 1'b1; exp_rd = 1'b1; exp_rdata = line_data[idx];
            exp_hit++; exp_ready = 1'b1;
            return;
        end
        if (rw) begin
            if (hit) line_data[idx] = wd;
            exp_we = 1'b1; exp_wdata = wd;
        end else begin
            exp_miss++; exp_we = 1'b0;
        end
        exp_req = 1'b1; exp_addr = {w, 2'b00};
        for (int i = 0; i < dly; i++) step();
        mem_ack = 1'b1;
        mem_rdata = rw ? $urandom : mem_rd(w);
        step();
        mem_ack = 1'b0;
        if (rw) begin
            mem_img[w] = wd;
        end else begin
            line_ok[idx] = 1'b1; line_word[idx] = w; line_data[idx] = mem_rdata;
            exp_rdata = mem_rdata;
        end
        exp_rd = !rw; exp_req = 1'b0; exp_valid = 1'b1; exp_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        int ixs [4] = '{0, 1, 16, 511};
        rst = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst mem_we", 32'(mem_we), 32'h0);
        check("rst cpu_rdata", cpu_rdata, 32'h0);
        step();

        // Miss with 2-cycle ack delay, then a 2-cycle hit
        mem_img[30'h10] = 32'hDEAD_BEEF;
        do_txn(1'b0, 32'h0000_0040, 32'h0, 2, 1'b0);
        check("t1 miss_count", 32'(miss_count), 32'h1);
        check("t1 rdata", cpu_rdata, 32'hDEAD_BEEF);
        step();
        do_txn(1'b0, 32'h0000_0040, 32'h0, 0, 1'b0);
        check("t1 hit valid", 32'(cpu_valid), 32'h1);
        check("t1 hit_count", 32'(hit_count), 32'h1);
        check("t1 hit no mem_req", 32'(mem_req), 32'h0);
        step();

        // Conflict misses on one index
        do_reset();
        step();
        do_txn(1'b0, 32'h0000_0040, 32'h0, 1, 1'b0); step();
        do_txn(1'b0, 32'h0000_0840, 32'h0, 0, 1'b0); step();
        do_txn(1'b0, 32'h0000_0040, 32'h0, 3, 1'b0);
        check("t2 miss_count", 32'(miss_count), 32'h3);
        check("t2 rdata", cpu_rdata, 32'hDEAD_BEEF);
        step();

        // Write-through to a cached line
        do_txn(1'b1, 32'h0000_0040, 32'h1234_5678, 1, 1'b0); step();
        do_txn(1'b0, 32'h0000_0040, 32'h0, 0, 1'b0);
        check("t3 rdata", cpu_rdata, 32'h1234_5678);
        check("t3 hit_count", 32'(hit_count), 32'h1);
        check("t3 miss_count", 32'(miss_count), 32'h3);
        step();

        // Write to an uncached line does not allocate
        do_txn(1'b1, 32'h0000_0100, 32'hCAFE_0001, 0, 1'b0); step();
        do_txn(1'b0, 32'h0000_0100, 32'h0, 1, 1'b0);
        check("t4 miss_count", 32'(miss_count), 32'h4);
        check("t4 rdata", cpu_rdata, 32'hCAFE_0001);
        step();

        // Reset in the second MEM_RD cycle abandons the refill
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h0000_0200;
        step();
        cpu_req = 1'b0; exp_ready = 1'b0;
        step();
        exp_miss++; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_0200;
        step();
        rst = 1'b1;
        step();
        model_reset();
        rst = 1'b0;
        check("t5 mem_req", 32'(mem_req), 32'h0);
        check("t5 cpu_valid", 32'(cpu_valid), 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_ack = 1'b0;
        check("t5 late ack", 32'(cpu_valid), 32'h0);
        do_txn(1'b0, 32'h0000_0200, 32'h0, 0, 1'b0);
        check("t5 reread miss", 32'(miss_count), 32'h1);
        step();

        // cpu_req held high across four back-to-back hits
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b0, 32'h0000_0040 + 32'(4 * i), 32'h0, 1, 1'b0);
            step();
        end
        for (int i = 0; i < 4; i++) do_txn(1'b0, 32'h0000_0040 + 32'(4 * i), 32'h0, 0, i < 3);
        check("t6 hit_count", 32'(hit_count), 32'h4);
        step();

        // Randomized traffic over a few colliding lines
        for (int n = 0; n < 300; n++) begin
            int gap;
            a = (32'($urandom_range(2, 0)) << 11) | (32'(ixs[$urandom_range(3, 0)]) << 2)
                | 32'($urandom_range(3, 0));
            do_txn(($urandom_range(9, 0) < 3), a, $urandom, int'($urandom_range(3, 0)), 1'b0);
            gap = int'($urandom_range(2, 0));
            for (int g = 0; g < gap; g++) begin
                mem_ack = $urandom_range(1, 0) == 1;
                step();
                mem_ack = 1'b0;
            end
        end
        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
